// File: rtl/pb_run_ctrl.sv
// -----------------------------------------------------------------------------
// pb_run_ctrl
//   Pushbutton run controller for the CPU core. Debounces five board buttons
//   and sequences the core through a clock enable: timed core reset, halt,
//   single-step and free-run with a programmable enable divider. Also keeps
//   the LED display-page select.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   pb[4:0]    in   raw buttons (async): 0 run/stop, 1 step, 2 core reset,
//                   3 page next, 4 page prev
//   cpu_halted in   core has executed a halt (level, clk domain)
//   cpu_en     out  core clock enable (registered)
//   cpu_rst    out  core synchronous reset, active-high (registered)
//   running    out  high while free-running (registered)
//   disp_sel   out  LED display page (registered)
// -----------------------------------------------------------------------------
module pb_run_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [7:0]  RST_CYCLES = 8'd16,
  parameter logic [23:0] RUN_DIV    = 24'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] pb,
  input  logic       cpu_halted,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic       running,
  output logic [1:0] disp_sel
);

  typedef enum logic [1:0] {S_CRST, S_HALT, S_RUN, S_STEP} state_t;

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, per-bit debounce, rising-edge press pulse
  // ---------------------------------------------------------------------------
  logic [4:0]  r_sync1, r_sync2;
  logic [4:0]  r_deb, r_deb_d;
  logic [4:0]  r_press;
  logic [15:0] r_deb_cnt [5];

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its sources, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      // NOTE: this is five small counters held in flops, not a RAM, so
      // clearing the whole array in reset costs nothing special.
      for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= pb;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // One pulse, one cycle after the debounced level rises.
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_CYCLES - 16'd1) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_rst_cnt, w_rst_cnt_nxt;
  logic [23:0] r_div, w_div_nxt;
  logic        r_cpu_en, w_cpu_en_nxt;
  logic        r_cpu_rst, w_cpu_rst_nxt;
  logic        r_running, w_running_nxt;
  logic [1:0]  r_disp_sel, w_disp_sel_nxt;

  // NOTE: every signal gets a default before the case so no path leaves a
  // combinational output unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_div_nxt     = r_div;
    w_cpu_en_nxt  = 1'b0;
    w_cpu_rst_nxt = 1'b0;
    w_running_nxt = 1'b0;

    // A reset press wins over everything else outside CRST; inside CRST it
    // is ignored and does not restart the reset timer.
    if (r_state != S_CRST && r_press[2]) begin
      w_state_nxt   = S_CRST;
      w_cpu_rst_nxt = 1'b1;
      w_rst_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_CRST: begin
          if (r_rst_cnt == RST_CYCLES - 8'd1) begin
            w_state_nxt   = S_HALT;
            w_rst_cnt_nxt = '0;
          end else begin
            w_cpu_rst_nxt = 1'b1;
            w_rst_cnt_nxt = r_rst_cnt + 8'd1;
          end
        end
        S_HALT: begin
          // Run beats step when both arrive together.
          if (!cpu_halted && r_press[0]) begin
            w_state_nxt   = S_RUN;
            w_running_nxt = 1'b1;
            w_div_nxt     = '0;
          end else if (!cpu_halted && r_press[1]) begin
            w_state_nxt  = S_STEP;
            w_cpu_en_nxt = 1'b1;
          end
        end
        S_STEP: begin
          w_state_nxt = S_HALT;
        end
        S_RUN: begin
          if (cpu_halted || r_press[0]) begin
            // Leaving on a halt also suppresses a pulse due this cycle.
            w_state_nxt = S_HALT;
          end else begin
            w_running_nxt = 1'b1;
            if (r_div == RUN_DIV - 24'd1) begin
              w_cpu_en_nxt = 1'b1;
              w_div_nxt    = '0;
            end else begin
              w_div_nxt = r_div + 24'd1;
            end
          end
        end
        default: begin
          w_state_nxt   = S_CRST;
          w_cpu_rst_nxt = 1'b1;
          w_rst_cnt_nxt = '0;
        end
      endcase
    end

    // Page select runs in every state; opposing presses cancel.
    case ({r_press[4], r_press[3]})
      2'b01:   w_disp_sel_nxt = r_disp_sel + 2'd1;
      2'b10:   w_disp_sel_nxt = r_disp_sel - 2'd1;
      default: w_disp_sel_nxt = r_disp_sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CRST;
      r_rst_cnt  <= '0;
      r_div      <= '0;
      r_cpu_en   <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_running  <= 1'b0;
      r_disp_sel <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_div      <= w_div_nxt;
      r_cpu_en   <= w_cpu_en_nxt;
      r_cpu_rst  <= w_cpu_rst_nxt;
      r_running  <= w_running_nxt;
      r_disp_sel <= w_disp_sel_nxt;
    end
  end

  assign cpu_en   = r_cpu_en;
  assign cpu_rst  = r_cpu_rst;
  assign running  = r_running;
  assign disp_sel = r_disp_sel;

endmodule

// File: tb/tb_pb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pb_run_ctrl
//   Self-checking bench for pb_run_ctrl (DEB_CYCLES=4, RST_CYCLES=3,
//   RUN_DIV=2). A behavioural model tracks the expected outputs every cycle;
//   directed scenarios add hand-computed expectations, then random button
//   and halt activity exercises the rest.
// -----------------------------------------------------------------------------
module tb_pb_run_ctrl;

  localparam int DEB = 4;
  localparam int RSTC = 3;
  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pb;
  logic       cpu_halted;
  logic       cpu_en, cpu_rst, running;
  logic [1:0] disp_sel;

  int total = 0;
  int bad   = 0;

  pb_run_ctrl #(
    .DEB_CYCLES(16'(DEB)),
    .RST_CYCLES(8'(RSTC)),
    .RUN_DIV   (24'(DIV))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .cpu_halted(cpu_halted),
    .cpu_en    (cpu_en),
    .cpu_rst   (cpu_rst),
    .running   (running),
    .disp_sel  (disp_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Button view: the level accepted after DEB consecutive
  // differing samples of the input as seen two edges late; a press is the
  // edge after acceptance of a 0->1 change. Run mode is described by the age
  // since entry, reset by cycles remaining.
  // ---------------------------------------------------------------------------
  typedef enum {M_CRST, M_HALT, M_RUN, M_STEP} mode_t;

  logic [4:0] m_seen1, m_seen2;
  logic [4:0] m_level, m_level_prev, m_press;
  int         m_diff_run [5];
  mode_t      m_mode;
  int         m_rst_left, m_age;
  logic       m_en, m_crst, m_running;
  logic [1:0] m_sel;
  bit         m_valid = 0;

  always @(posedge clk) begin
    logic [4:0] p;
    logic [4:0] sv;
    p  = m_press;
    sv = m_seen2;
    if (rst) begin
      m_seen1 = '0; m_seen2 = '0;
      m_level = '0; m_level_prev = '0; m_press = '0;
      for (int i = 0; i < 5; i++) m_diff_run[i] = 0;
      m_mode = M_CRST; m_rst_left = RSTC; m_age = 0;
      m_en = 0; m_crst = 1; m_running = 0; m_sel = 0;
    end else begin
      if (p[3] && !p[4]) m_sel = 2'(m_sel + 2'd1);
      else if (p[4] && !p[3]) m_sel = 2'(m_sel - 2'd1);

      m_en = 0;
      if (m_mode != M_CRST && p[2]) begin
        m_mode = M_CRST; m_rst_left = RSTC;
      end else begin
        case (m_mode)
          M_CRST: begin
            m_rst_left--;
            if (m_rst_left == 0) m_mode = M_HALT;
          end
          M_HALT: begin
            if (!cpu_halted && p[0]) begin m_mode = M_RUN; m_age = 0; end
            else if (!cpu_halted && p[1]) begin m_mode = M_STEP; m_en = 1; end
          end
          M_STEP: m_mode = M_HALT;
          M_RUN: begin
            if (p[0] || cpu_halted) m_mode = M_HALT;
            else begin
              m_age++;
              m_en = (m_age % DIV) == 0;
            end
          end
        endcase
      end
      m_crst    = (m_mode == M_CRST);
      m_running = (m_mode == M_RUN);

      m_press      = m_level & ~m_level_prev;
      m_level_prev = m_level;
      for (int i = 0; i < 5; i++) begin
        if (sv[i] != m_level[i]) begin
          m_diff_run[i]++;
          if (m_diff_run[i] >= DEB) begin
            m_level[i]    = sv[i];
            m_diff_run[i] = 0;
          end
        end else begin
          m_diff_run[i] = 0;
        end
      end
      m_seen2 = m_seen1;
      m_seen1 = pb;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_cpu_en",   {31'b0, cpu_en},  {31'b0, m_en});
      check("model_cpu_rst",  {31'b0, cpu_rst}, {31'b0, m_crst});
      check("model_running",  {31'b0, running}, {31'b0, m_running});
      check("model_disp_sel", {30'b0, disp_sel}, {30'b0, m_sel});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus, all driven on the falling edge
  // ---------------------------------------------------------------------------
  task automatic press_release(input logic [4:0] mask);
    pb = mask;
    tick(10);
    pb = '0;
    tick(10);
  endtask

  task automatic wait_running(input logic want, input string name);
    int n;
    n = 0;
    while (running !== want && n < 40) begin tick; n++; end
    check(name, {31'b0, running}, {31'b0, want});
  endtask

  initial begin
    int k, c, r;
    rst = 1'b1; pb = '0; cpu_halted = 1'b0;

    // 1. reset
    tick(2);
    check("rst_cpu_rst",  {31'b0, cpu_rst}, 32'd1);
    check("rst_cpu_en",   {31'b0, cpu_en},  32'd0);
    check("rst_running",  {31'b0, running}, 32'd0);
    check("rst_disp_sel", {30'b0, disp_sel}, 32'd0);
    rst = 1'b0;
    k = 0;
    do begin tick; k++; end while (cpu_rst && k < 20);
    check("rst_release_cycles", k, 32'd3);
    check("rst_then_halt", {31'b0, running}, 32'd0);

    // 2. bouncing step button, then a stable hold, then release
    c = 0;
    for (int i = 0; i < 10; i++) begin
      pb[1] = ((i / 2) % 2) == 0;
      tick;
      if (cpu_en) c++;
    end
    check("bounce_no_en", c, 32'd0);
    pb[1] = 1'b1;
    c = 0;
    for (int i = 0; i < 20; i++) begin tick; if (cpu_en) c++; end
    check("step_one_pulse", c, 32'd1);
    pb[1] = 1'b0;
    c = 0;
    for (int i = 0; i < 20; i++) begin tick; if (cpu_en) c++; end
    check("release_no_en", c, 32'd0);

    // 3. run divider
    pb = 5'b00001;
    wait_running(1'b1, "run_enter");
    pb = '0;
    k = 0;
    do begin tick; k++; end while (!cpu_en && k < 10);
    check("run_first_pulse", k, 32'd2);
    c = 0;
    for (int i = 0; i < 8; i++) begin tick; if (cpu_en) c++; end
    check("run_pulse_rate", c, 32'd4);
    pb = 5'b00001;
    wait_running(1'b0, "run_stop");
    pb = '0;
    c = 0;
    for (int i = 0; i < 10; i++) begin tick; if (cpu_en) c++; end
    check("stop_no_en", c, 32'd0);

    // 4. core halt on the pulse cycle
    pb = 5'b00001;
    wait_running(1'b1, "halt_run_enter");
    pb = '0;
    tick(3);
    cpu_halted = 1'b1;
    tick;
    check("halt_en_suppressed", {31'b0, cpu_en},  32'd0);
    check("halt_left_run",      {31'b0, running}, 32'd0);
    c = 0; r = 0;
    pb = 5'b00001; for (int i = 0; i < 12; i++) begin tick; if (cpu_en) c++; if (running) r++; end
    pb = '0;       for (int i = 0; i < 10; i++) begin tick; if (cpu_en) c++; if (running) r++; end
    pb = 5'b00010; for (int i = 0; i < 12; i++) begin tick; if (cpu_en) c++; if (running) r++; end
    pb = '0;       for (int i = 0; i < 10; i++) begin tick; if (cpu_en) c++; if (running) r++; end
    check("halted_ignores_en",  c, 32'd0);
    check("halted_ignores_run", r, 32'd0);
    cpu_halted = 1'b0;
    tick(2);

    // 6. page wrap
    press_release(5'b10000);
    check("page_prev_wrap", {30'b0, disp_sel}, 32'd3);
    press_release(5'b01000);
    check("page_next_wrap", {30'b0, disp_sel}, 32'd0);
    press_release(5'b01000);
    check("page_next", {30'b0, disp_sel}, 32'd1);
    press_release(5'b11000);
    check("page_both", {30'b0, disp_sel}, 32'd1);

    // 5. reset press mid-run
    pb = 5'b00001;
    wait_running(1'b1, "crst_run_enter");
    pb = '0;
    tick(4);
    pb = 5'b00100;
    k = 0;
    while (!cpu_rst && k < 40) begin tick; k++; end
    check("crst_rise",    {31'b0, cpu_rst}, 32'd1);
    check("crst_running", {31'b0, running}, 32'd0);
    check("crst_en",      {31'b0, cpu_en},  32'd0);
    k = 0;
    while (cpu_rst && k < 20) begin k++; tick; end
    check("crst_cycles", k, 32'd3);
    pb = '0;
    tick(10);
    check("crst_page_kept", {30'b0, disp_sel}, 32'd1);
    check("crst_to_halt",   {31'b0, running},  32'd0);

    // random phase: the per-cycle model comparison carries the checking
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 80) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
      pb         = 5'($urandom);
      cpu_halted = ($urandom_range(0, 5) == 0);
      tick($urandom_range(1, 12));
    end
    pb = '0; cpu_halted = 1'b0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
